// File: rtl/fpg8_trap_sequencer.sv
// FPG8 trap entry sequencer: pushes PSW/PC, then loads PSW/PC from the vector slot
// of the highest-priority eligible source, with wait-state handshaking and bus timeout.
module fpg8_trap_sequencer #(
    parameter int unsigned       NUM_SRC    = 4,
    parameter int unsigned       ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 16'h0010,
    parameter int unsigned       WAIT_LIMIT = 8,
    localparam int unsigned      CAUSE_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               boundary,
    input  logic               privileged,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic [NUM_SRC-1:0] src_mask,
    input  logic [ADDR_W-1:0]  sp,
    input  logic               mem_ready,
    output logic               busy,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_re,
    output logic               mem_we,
    output logic [1:0]         wdata_sel,
    output logic               psw_load,
    output logic               pc_load,
    output logic               sp_load,
    output logic [ADDR_W-1:0]  sp_next,
    output logic [NUM_SRC-1:0] ack,
    output logic [CAUSE_W-1:0] cause,
    output logic               bus_fault
);

    localparam int unsigned WCNT_W = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WCNT_W-1:0] WLAST = WCNT_W'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PUSH_PSW, S_PUSH_PC, S_LOAD_PSW, S_LOAD_PC, S_DONE, S_FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [CAUSE_W-1:0]  cause_q, cause_d;
    logic [ADDR_W-1:0]   sp_l_q, sp_l_d;
    logic [ADDR_W-1:0]   sp_next_q, sp_next_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

    logic [NUM_SRC-1:0]  mask_eff, priv_gate, pend;
    logic [CAUSE_W-1:0]  pick_idx;
    logic                found;
    logic                mem_state;
    state_t              mem_nxt;
    logic [ADDR_W-1:0]   vec_addr;

    // Source 0 is non-maskable and survives the privileged gate.
    always_comb begin
        mask_eff    = src_mask;
        mask_eff[0] = 1'b0;
        priv_gate   = privileged ? NUM_SRC'(1) : '1;
        pend        = src_req & ~mask_eff & priv_gate;
        pick_idx    = '0;
        found       = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (pend[i] && !found) begin
                pick_idx = CAUSE_W'(i);
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        sp_l_d    = sp_l_q;
        sp_next_d = sp_next_q;
        wcnt_d    = wcnt_q;
        mem_state = 1'b0;
        mem_nxt   = S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (boundary && found) begin
                    state_d   = S_PUSH_PSW;
                    cause_d   = pick_idx;
                    sp_l_d    = sp;
                    sp_next_d = sp - ADDR_W'(4);
                    wcnt_d    = '0;
                end
            end
            S_PUSH_PSW: begin mem_state = 1'b1; mem_nxt = S_PUSH_PC;  end
            S_PUSH_PC:  begin mem_state = 1'b1; mem_nxt = S_LOAD_PSW; end
            S_LOAD_PSW: begin mem_state = 1'b1; mem_nxt = S_LOAD_PC;  end
            S_LOAD_PC:  begin mem_state = 1'b1; mem_nxt = S_DONE;     end
            S_DONE:     state_d = S_IDLE;
            S_FAULT:    state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        // Shared handshake/timeout handling for the four memory states.
        if (mem_state) begin
            if (mem_ready) begin
                state_d = mem_nxt;
                wcnt_d  = '0;
            end else if ((WAIT_LIMIT != 0) && (wcnt_q == WLAST)) begin
                state_d = S_FAULT;
                wcnt_d  = '0;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cause_q   <= '0;
            sp_l_q    <= '0;
            sp_next_q <= '0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            sp_l_q    <= sp_l_d;
            sp_next_q <= sp_next_d;
            wcnt_q    <= wcnt_d;
        end
    end

    assign vec_addr = VEC_BASE + (ADDR_W'(cause_q) << 2);

    always_comb begin
        busy      = (state_q != S_IDLE);
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        wdata_sel = 2'd0;
        psw_load  = 1'b0;
        pc_load   = 1'b0;
        sp_load   = 1'b0;
        ack       = '0;
        bus_fault = 1'b0;
        sp_next   = sp_next_q;
        cause     = cause_q;
        case (state_q)
            S_PUSH_PSW: begin
                mem_we = 1'b1; wdata_sel = 2'd1; mem_addr = sp_l_q - ADDR_W'(2);
            end
            S_PUSH_PC: begin
                mem_we = 1'b1; wdata_sel = 2'd2; mem_addr = sp_l_q - ADDR_W'(4);
            end
            S_LOAD_PSW: begin
                mem_re = 1'b1; mem_addr = vec_addr; psw_load = mem_ready;
            end
            S_LOAD_PC: begin
                mem_re = 1'b1; mem_addr = vec_addr + ADDR_W'(2); pc_load = mem_ready;
            end
            S_DONE: begin
                sp_load = 1'b1;
                ack     = NUM_SRC'(1) << cause_q;
            end
            S_FAULT:  bus_fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fpg8_trap_sequencer.sv
// Scoreboard bench for fpg8_trap_sequencer: per-cycle expected outputs are queued as
// stimulus is driven and compared on the falling clock edge.
module tb_fpg8_trap_sequencer;

    localparam int WL = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        boundary = 1'b0;
    logic        privileged = 1'b0;
    logic [3:0]  src_req = '0;
    logic [3:0]  src_mask = '0;
    logic [15:0] sp = '0;
    logic        mem_ready = 1'b0;
    logic        busy, mem_re, mem_we, psw_load, pc_load, sp_load, bus_fault;
    logic [15:0] mem_addr, sp_next;
    logic [1:0]  wdata_sel, cause;
    logic [3:0]  ack;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct packed {
        logic        busy;
        logic [15:0] addr;
        logic        we;
        logic        re;
        logic [1:0]  sel;
        logic        pswl;
        logic        pcl;
        logic        spl;
        logic [3:0]  ack;
        logic        bf;
        logic        lat;
        logic [1:0]  cause;
        logic [15:0] spn;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    fpg8_trap_sequencer #(
        .NUM_SRC(4), .ADDR_W(16), .VEC_BASE(16'h0010), .WAIT_LIMIT(WL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .boundary(boundary), .privileged(privileged),
        .src_req(src_req), .src_mask(src_mask), .sp(sp), .mem_ready(mem_ready),
        .busy(busy), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .wdata_sel(wdata_sel), .psw_load(psw_load), .pc_load(pc_load),
        .sp_load(sp_load), .sp_next(sp_next), .ack(ack), .cause(cause),
        .bus_fault(bus_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("busy",      32'(busy),      32'(mon_e.busy));
            check("mem_addr",  32'(mem_addr),  32'(mon_e.addr));
            check("mem_we",    32'(mem_we),    32'(mon_e.we));
            check("mem_re",    32'(mem_re),    32'(mon_e.re));
            check("wdata_sel", 32'(wdata_sel), 32'(mon_e.sel));
            check("psw_load",  32'(psw_load),  32'(mon_e.pswl));
            check("pc_load",   32'(pc_load),   32'(mon_e.pcl));
            check("sp_load",   32'(sp_load),   32'(mon_e.spl));
            check("ack",       32'(ack),       32'(mon_e.ack));
            check("bus_fault", 32'(bus_fault), 32'(mon_e.bf));
            if (mon_e.lat) begin
                check("cause",   32'(cause),   32'(mon_e.cause));
                check("sp_next", 32'(sp_next), 32'(mon_e.spn));
            end
        end
    end

    task automatic idle_exp();
        exp_t e;
        e = '0;
        sb_q.push_back(e);
    endtask

    // cause_exp < 0 means no entry is expected; stall_st selects which memory state
    // (0..3) sees stall_n cycles of mem_ready=0; disturb scrambles inputs while busy.
    task automatic run_trap(input logic [15:0] sp_v, input logic [3:0] req,
                            input logic [3:0] mask, input logic priv, input int cause_exp,
                            input int stall_st, input int stall_n, input logic disturb);
        exp_t        e;
        logic [15:0] vec;
        logic        mr;
        int          k;
        @(posedge clk); #1;
        sp = sp_v; src_req = req; src_mask = mask; privileged = priv;
        boundary = 1'b1; mem_ready = 1'b1;
        idle_exp();
        @(posedge clk); #1;
        boundary = 1'b0;
        if (cause_exp < 0) begin
            idle_exp();
            return;
        end
        if (disturb) begin
            src_req = '0; src_mask = '1; privileged = 1'b1; sp = ~sp_v;
        end
        vec = 16'h0010 + 16'(cause_exp * 4);
        for (int st = 0; st < 4; st++) begin
            k = 0;
            forever begin
                mr = (st == stall_st && k < stall_n) ? 1'b0 : 1'b1;
                mem_ready = mr;
                e = '0;
                e.busy = 1'b1; e.lat = 1'b1; e.cause = cause_exp[1:0]; e.spn = sp_v - 16'd4;
                case (st)
                    0: begin e.addr = sp_v - 16'd2; e.we = 1'b1; e.sel = 2'd1; end
                    1: begin e.addr = sp_v - 16'd4; e.we = 1'b1; e.sel = 2'd2; end
                    2: begin e.addr = vec;          e.re = 1'b1; e.pswl = mr;   end
                    default: begin e.addr = vec + 16'd2; e.re = 1'b1; e.pcl = mr; end
                endcase
                sb_q.push_back(e);
                @(posedge clk); #1;
                if (mr) break;
                if (k == WL - 1) begin
                    e = '0;
                    e.busy = 1'b1; e.bf = 1'b1; e.lat = 1'b1;
                    e.cause = cause_exp[1:0]; e.spn = sp_v - 16'd4;
                    sb_q.push_back(e);
                    @(posedge clk); #1;
                    idle_exp();
                    return;
                end
                k++;
            end
        end
        e = '0;
        e.busy = 1'b1; e.spl = 1'b1; e.ack = 4'b0001 << cause_exp;
        e.lat = 1'b1; e.cause = cause_exp[1:0]; e.spn = sp_v - 16'd4;
        sb_q.push_back(e);
        @(posedge clk); #1;
        idle_exp();
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"},    32'(busy),      32'd0);
        check({pfx, "_addr"},    32'(mem_addr),  32'd0);
        check({pfx, "_re_we"},   32'({mem_re, mem_we}), 32'd0);
        check({pfx, "_sel"},     32'(wdata_sel), 32'd0);
        check({pfx, "_loads"},   32'({psw_load, pc_load, sp_load}), 32'd0);
        check({pfx, "_ack"},     32'(ack),       32'd0);
        check({pfx, "_cause"},   32'(cause),     32'd0);
        check({pfx, "_fault"},   32'(bus_fault), 32'd0);
        check({pfx, "_sp_next"}, 32'(sp_next),   32'd0);
    endtask

    initial begin
        #3;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Basic entry, cause 2
        run_trap(16'h0100, 4'b0100, 4'b0000, 1'b0, 2, -1, 0, 1'b0);
        // Priority with masked source 1: source 0 wins
        run_trap(16'h0100, 4'b1011, 4'b0010, 1'b0, 0, -1, 0, 1'b0);
        // Privileged blocks all but source 0
        run_trap(16'h0100, 4'b1010, 4'b0010, 1'b1, -1, -1, 0, 1'b0);
        run_trap(16'h0100, 4'b0001, 4'b0000, 1'b1, 0, -1, 0, 1'b0);
        // Three wait cycles in PUSH_PC
        run_trap(16'h0100, 4'b0100, 4'b0000, 1'b0, 2, 1, 3, 1'b0);
        // Bus timeout in LOAD_PSW
        run_trap(16'h0100, 4'b0100, 4'b0000, 1'b0, 2, 2, 100, 1'b0);
        // Stack pointer wrap
        run_trap(16'h0002, 4'b0100, 4'b0000, 1'b0, 2, -1, 0, 1'b0);
        // Inputs change while busy; latched cause 3 completes
        run_trap(16'h0200, 4'b1000, 4'b0000, 1'b0, 3, -1, 0, 1'b1);
        // Non-maskable wait on LOAD_PC just short of the limit
        run_trap(16'h0100, 4'b0001, 4'b1111, 1'b0, 0, 3, WL - 1, 1'b0);

        // Asynchronous reset in LOAD_PC
        @(posedge clk); #1;
        sp = 16'h0100; src_req = 4'b0100; src_mask = '0; privileged = 1'b0;
        boundary = 1'b1; mem_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            boundary = 1'b0;
        end
        mem_ready = 1'b0;
        #2;
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_addr", 32'(mem_addr), 32'h001A);
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
